ibex_cpi_stack_sampler: RTL

Sits directly downstream of the per-cycle CPI-stack classifier. It consumes that stage's one-hot category strobes (base, icache, bpred, dcache, ex, dependency) and accumulates them over a programmable cycle interval. At each interval boundary it snapshots the counts into a small sample FIFO. Samples are streamed out over a valid/ready port as 7 beats each, for a trace writer or debug buffer.

---
 rtl/ibex_cpi_stack_sampler.sv | 115 +++++++++++
 1 files changed

// File: rtl/ibex_cpi_stack_sampler.sv
// Accumulates per-cycle CPI-stack category strobes over a programmable interval and streams each sample as 7 beats.
// First beat is visible one cycle after the snapshot edge. Stalls hold the beat stable. A full FIFO drops the sample and sets the sticky overflow flag.
module ibex_cpi_stack_sampler #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned INTERVAL_W = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    input  logic                  base_i,
    input  logic                  icache_i,
    input  logic                  bpred_i,
    input  logic                  dcache_i,
    input  logic                  ex_i,
    input  logic                  dep_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CNT_W-1:0]      out_data_o,
    output logic [2:0]            out_cat_o,
    output logic                  out_last_o,
    output logic                  overflow_o
);

    localparam int unsigned NCNT  = 7;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef logic [NCNT-1:0][CNT_W-1:0] sample_t;

    logic [NCNT-1:0] inc;
    sample_t         acc_q, acc_d, acc_inc;
    logic [CNT_W:0]  cyc_next;
    logic            snap;

    sample_t         mem_q [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            fifo_full, fifo_empty, push, drop;

    logic [2:0]      beat_q, beat_d;
    logic            xfer, pop;
    logic            overflow_q, overflow_d;

    // Index 0 is the cycle counter, which counts every enabled cycle.
    assign inc = {dep_i, ex_i, dcache_i, bpred_i, icache_i, base_i, 1'b1} & {NCNT{enable_i}};

    always_comb begin
        acc_inc = acc_q;
        for (int i = 0; i < NCNT; i++) begin
            if (inc[i] && (acc_q[i] != {CNT_W{1'b1}})) begin
                acc_inc[i] = acc_q[i] + CNT_W'(1);
            end
        end
    end

    // One extra bit, so a saturated cycle counter still compares correctly.
    assign cyc_next = {1'b0, acc_q[0]} + (CNT_W+1)'(1);
    assign snap     = enable_i && (interval_i != '0) && (cyc_next >= (CNT_W+1)'(interval_i));

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Fullness is judged before this cycle's pop.
    assign push = snap && !fifo_full;
    assign drop = snap && fifo_full;

    assign out_valid_o = !fifo_empty;
    assign xfer        = out_valid_o && out_ready_i;
    assign pop         = xfer && (beat_q == 3'd6);

    assign out_data_o = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]][beat_q];
    assign out_cat_o  = beat_q;
    assign out_last_o = (beat_q == 3'd6);
    assign overflow_o = overflow_q;

    always_comb begin
        acc_d      = snap ? '0 : acc_inc;
        wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
        beat_d     = xfer ? (pop ? 3'd0 : beat_q + 3'd1) : beat_q;
        overflow_d = overflow_q | drop;
        if (clear_i) begin
            acc_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            beat_d     = 3'd0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage needs no reset because the pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= acc_inc;
        end
    end

endmodule
